calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Command sequencer that owns the button/switch inputs of the `calc` accumulator datapath and drives them from a buffered command stream, so calc is no longer driven directly by pushbuttons. It accepts {op, operand, clear} commands over a valid/ready port and buffers them in a small FIFO. It replays each command into calc as a setup / one-cycle `btnd` strobe / settle sequence, then returns the captured `led` accumulator value over a valid/ready response port. It sits between a host/UART front end and `calc`.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `SETTLE_CYCLES`, 1: idle cycles after the strobe before `calc_led` is sampled; ≥1.
- `DATA_W`, 16: operand/result width; must match calc.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO not full; a command is accepted on an edge where `cmd_valid & cmd_ready`.
- `cmd_clr` in 1: 1 = clear accumulator (ignores op/operand).
- `cmd_op` in 3: {btnl, btnc, btnr} ALU select.
- `cmd_operand` in DATA_W: value for calc `sw`.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_data` out DATA_W: `calc_led` captured for the completed command.
- `busy` out 1: FSM not in IDLE, or FIFO non-empty.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `calc_btnu` out 1: calc reset (active-high).
- `calc_btnd` out 1: calc execute strobe.
- `calc_btnl`, `calc_btnc`, `calc_btnr` out 1 each: op select.
- `calc_sw` out DATA_W: operand.
- `calc_led` in DATA_W: calc accumulator.

## Operation
- States: INIT, IDLE, SETUP, STROBE, SETTLE, RESP.
- Reset (`rst_n`=0): state INIT, FIFO empty. Outputs: `calc_btnu`=1, `calc_btnd`=0, op bits 0, `calc_sw`=0, `rsp_valid`=0, `rsp_data`=0, `cmd_ready`=0, `busy`=1, `fifo_level`=0.
- INIT: held for exactly one cycle after reset release with `calc_btnu`=1, then go to IDLE with `calc_btnu`=0. `cmd_ready`=!full in every state except INIT.
- IDLE: if the FIFO is non-empty, pop the head, register op/operand/clr into the calc drive registers, and go to SETUP. Otherwise stay.
- SETUP: one cycle. `calc_sw` and op bits are stable, `calc_btnd`=0.
- STROBE: one cycle. Normal command: `calc_btnd`=1. Clear command: `calc_btnu`=1 instead, and `calc_btnd` stays 0.
- SETTLE: SETTLE_CYCLES cycles, strobes low. On the last cycle, capture `calc_led` into `rsp_data` and go to RESP.
- RESP: `rsp_valid`=1 and `rsp_data` are held stable until an edge with `rsp_ready`=1. That edge goes to IDLE with `rsp_valid`=0. There is no response bypass: at most one command is in flight.
- `calc_sw` and op bits keep the last command's values until the next pop; they are never glitched between commands.
- FIFO: push and pop on the same edge are allowed at any level, and `fifo_level` is unchanged. Push is blocked when full. Pop occurs only from IDLE.
- Mid-operation reset: abort immediately, flush the FIFO, go to INIT, and drop any pending response. `calc_btnu` is asserted so calc is cleared.

## Timing
- Command accepted at edge E0 into an empty FIFO with the FSM in IDLE:
  - Pop at E1; SETUP spans E1–E2.
  - `calc_btnd`=1 during E2–E3; calc updates its accumulator at E3.
  - SETTLE spans E3 to E3+SETTLE_CYCLES.
  - `rsp_valid` rises at E4 with the default setting, giving a latency of 3+SETTLE_CYCLES cycles.
- Back-to-back throughput: one command per 4+SETTLE_CYCLES cycles when `rsp_ready` is held at 1.
- All outputs are registered; no combinational path from `cmd_*` or `rsp_ready` to the `calc_*` outputs.

## Structure
- Package `calc_seq_pkg`: state enum, `OP_W`=3, `DATA_W` default, and the command struct {clr, op, operand}.
- Sub-module `calc_cmd_fifo`: synchronous FIFO with depth FIFO_DEPTH and width 1+3+DATA_W, providing full/empty/level. The sequencer FSM and drive registers live in the top.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then release. `calc_btnu`=1 through the cycle after release, then 0. `cmd_ready` goes 1 one cycle after release. `rsp_valid`=0 throughout.
- Single op: push {clr=0, op=3'b011, operand=16'h1234} at E0.
  - Expect `calc_sw`=16'h1234 and btnl/btnc/btnr=0/1/1 from E1.
  - `calc_btnd` is high exactly during E2–E3.
  - `rsp_valid` at E4 with `rsp_data` equal to calc's `led`, checked against the calc model.
- Clear: after a nonzero result, push {clr=1}. `calc_btnu` pulses for one cycle, `calc_btnd` never rises, and `rsp_data`=16'h0000.
- Fill/backpressure: hold `rsp_ready`=0 and push 6 commands.
  - `cmd_ready` drops when `fifo_level`=4.
  - The first response is held stable. Releasing `rsp_ready` drains all commands in order with one `calc_btnd` pulse each.
- Simultaneous push/pop: push on the same edge that IDLE pops at level 1. `fifo_level` stays 1 and no command is lost or duplicated.
- Reset mid-op: deassert `rst_n` during STROBE with 2 commands queued. The FIFO empties, `rsp_valid`=0, no further `calc_btnd` pulses occur, and INIT is re-entered.

Source files
------------

// File: rtl/calc_seq_pkg.sv
// Shared types for the calc command sequencer.
// State encoding, op width and the buffered command layout.
package calc_seq_pkg;

    localparam int OP_W   = 3;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SETUP,
        STROBE,
        SETTLE,
        RESP
    } state_t;

    typedef struct packed {
        logic              clr;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] operand;
    } cmd_t;

endpackage

// File: rtl/calc_cmd_fifo.sv
// Command FIFO for the calc sequencer.
// Head entry is visible on rdata_o while the FIFO is non-empty.
module calc_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointer and occupancy update; simultaneous push/pop keeps the level.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (do_pop && !do_push) begin
            level_d = level_q - 1'b1;
        end
    end

    // Pointer/level registers; reset flushes the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write; contents need no reset since level gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Replays buffered commands into calc as setup/strobe/settle,
// then returns the captured accumulator over a response port.
module calc_sequencer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int DATA_W        = calc_seq_pkg::DATA_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_clr,
    input  logic [calc_seq_pkg::OP_W-1:0] cmd_op,
    input  logic [DATA_W-1:0]             cmd_operand,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          calc_btnu,
    output logic                          calc_btnd,
    output logic                          calc_btnl,
    output logic                          calc_btnc,
    output logic                          calc_btnr,
    output logic [DATA_W-1:0]             calc_sw,
    input  logic [DATA_W-1:0]             calc_led
);

    import calc_seq_pkg::*;

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CMD_W = 1 + OP_W + DATA_W;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    state_t             state_q, state_d;
    logic               clr_q, clr_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [DATA_W-1:0]  sw_q, sw_d;
    logic               btnu_q, btnu_d;
    logic               btnd_q, btnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

    logic               push;
    logic               pop;
    logic [CMD_W-1:0]   head;
    logic               full;
    logic               empty;
    logic [LVL_W-1:0]   level;

    assign push = cmd_valid & cmd_ready;

    calc_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({cmd_clr, cmd_op, cmd_operand}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    assign cmd_ready  = (state_q != INIT) && !full;
    assign busy       = (state_q != IDLE) || !empty;
    assign fifo_level = level;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign calc_btnu  = btnu_q;
    assign calc_btnd  = btnd_q;
    assign calc_btnl  = op_q[2];
    assign calc_btnc  = op_q[1];
    assign calc_btnr  = op_q[0];
    assign calc_sw    = sw_q;

    // Next state and registered drive values; strobes default low.
    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        op_d        = op_q;
        sw_d        = sw_q;
        btnu_d      = 1'b0;
        btnd_d      = 1'b0;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        pop         = 1'b0;
        unique case (state_q)
            INIT: begin
                state_d = IDLE;
            end
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    clr_d   = head[CMD_W-1];
                    op_d    = head[DATA_W +: OP_W];
                    sw_d    = head[DATA_W-1:0];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                btnd_d  = !clr_q;
                btnu_d  = clr_q;
                state_d = STROBE;
            end
            STROBE: begin
                cnt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    rsp_data_d  = calc_led;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // State and drive registers; reset holds calc in clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            clr_q       <= 1'b0;
            op_q        <= '0;
            sw_q        <= '0;
            btnu_q      <= 1'b1;
            btnd_q      <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            op_q        <= op_d;
            sw_q        <= sw_d;
            btnu_q      <= btnu_d;
            btnd_q      <= btnd_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer with a calc stand-in and an
// in-order accumulator reference model.
module tb_calc_sequencer;

    import calc_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_clr;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_operand;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        busy;
    logic [2:0]  fifo_level;
    logic        calc_btnu;
    logic        calc_btnd;
    logic        calc_btnl;
    logic        calc_btnc;
    logic        calc_btnr;
    logic [15:0] calc_sw;
    logic [15:0] calc_led = '0;

    int n_assert = 0;
    int n_fail   = 0;
    int btnd_cnt = 0;
    int btnu_cnt = 0;

    logic [15:0] model_acc;
    logic [15:0] exp_q [$];

    calc_sequencer #(
        .FIFO_DEPTH    (4),
        .SETTLE_CYCLES (1),
        .DATA_W        (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_clr     (cmd_clr),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .calc_btnu   (calc_btnu),
        .calc_btnd   (calc_btnd),
        .calc_btnl   (calc_btnl),
        .calc_btnc   (calc_btnc),
        .calc_btnr   (calc_btnr),
        .calc_sw     (calc_sw),
        .calc_led    (calc_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] alu(input logic [2:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return b;
            3'd6:    return a << 1;
            default: return ~a;
        endcase
    endfunction

    // calc stand-in: registered accumulator with clear/execute buttons
    always @(posedge clk) begin
        if (calc_btnu) begin
            calc_led <= '0;
        end else if (calc_btnd) begin
            calc_led <= alu({calc_btnl, calc_btnc, calc_btnr}, calc_led, calc_sw);
        end
    end

    // strobe activity counters
    always @(posedge clk) begin
        btnd_cnt <= btnd_cnt + (calc_btnd ? 1 : 0);
        btnu_cnt <= btnu_cnt + ((calc_btnu && rst_n) ? 1 : 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic clr, input logic [2:0] op,
                        input logic [15:0] v);
        int k;
        cmd_valid   = 1'b1;
        cmd_clr     = clr;
        cmd_op      = op;
        cmd_operand = v;
        k = 0;
        while (!cmd_ready && k < 100) begin
            tick();
            k++;
        end
        chk("push_accept", 32'(cmd_ready), 1);
        if (cmd_ready) begin
            tick();
            model_acc = clr ? 16'h0000 : alu(op, model_acc, v);
            exp_q.push_back(model_acc);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag);
        int k;
        logic [15:0] e;
        rsp_ready = 1'b1;
        k = 0;
        while (!rsp_valid && k < 100) begin
            tick();
            k++;
        end
        chk({tag, "_valid"}, 32'(rsp_valid), 1);
        if (rsp_valid) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e = 16'hxxxx;
            end
            chk(tag, 32'(rsp_data), 32'(e));
            tick();
            chk({tag, "_drop"}, 32'(rsp_valid), 0);
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] v;
        logic [2:0]  op;
        int          snap_d;
        int          snap_u;
        int          k;

        rst_n       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_clr     = 1'b0;
        cmd_op      = '0;
        cmd_operand = '0;
        rsp_ready   = 1'b0;
        model_acc   = '0;
        #1 rst_n = 1'b0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_btnu", 32'(calc_btnu), 1);
        chk("rst_btnd", 32'(calc_btnd), 0);
        chk("rst_op", 32'({calc_btnl, calc_btnc, calc_btnr}), 0);
        chk("rst_sw", 32'(calc_sw), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_level", 32'(fifo_level), 0);
        rst_n = 1'b1;
        chk("init_btnu", 32'(calc_btnu), 1);
        chk("init_cmd_ready", 32'(cmd_ready), 0);
        tick();
        chk("idle_btnu", 32'(calc_btnu), 0);
        chk("idle_cmd_ready", 32'(cmd_ready), 1);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_rsp_valid", 32'(rsp_valid), 0);

        // single op with cycle-exact timing
        snap_d = btnd_cnt;
        push(1'b0, 3'b011, 16'h1234);
        chk("e0_level", 32'(fifo_level), 1);
        chk("e0_busy", 32'(busy), 1);
        tick();
        chk("e1_sw", 32'(calc_sw), 32'h1234);
        chk("e1_op", 32'({calc_btnl, calc_btnc, calc_btnr}), 32'b011);
        chk("e1_btnd", 32'(calc_btnd), 0);
        chk("e1_level", 32'(fifo_level), 0);
        tick();
        chk("e2_btnd", 32'(calc_btnd), 1);
        tick();
        chk("e3_btnd", 32'(calc_btnd), 0);
        chk("e3_rsp_valid", 32'(rsp_valid), 0);
        tick();
        chk("e4_rsp_valid", 32'(rsp_valid), 1);
        chk("e4_rsp_data", 32'(rsp_data), 32'(exp_q[0]));
        repeat (2) tick();
        chk("hold_rsp_valid", 32'(rsp_valid), 1);
        chk("hold_sw", 32'(calc_sw), 32'h1234);
        get_rsp("single");
        chk("single_pulses", btnd_cnt - snap_d, 1);

        // clear after a nonzero result
        snap_d = btnd_cnt;
        snap_u = btnu_cnt;
        push(1'b1, 3'($urandom_range(0, 7)), 16'($urandom));
        get_rsp("clear");
        chk("clear_btnu_pulse", btnu_cnt - snap_u, 1);
        chk("clear_no_btnd", btnd_cnt - snap_d, 0);

        // randomized single commands
        for (int i = 0; i < 10; i++) begin
            push(($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)),
                 16'($urandom));
            get_rsp("rand");
        end

        // fill and backpressure
        snap_d = btnd_cnt;
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 3'($urandom_range(0, 7)), 16'($urandom));
        end
        chk("fill_level", 32'(fifo_level), 4);
        chk("fill_cmd_ready", 32'(cmd_ready), 0);
        k = 0;
        while (!rsp_valid && k < 50) begin
            tick();
            k++;
        end
        chk("fill_rsp_valid", 32'(rsp_valid), 1);
        op = 3'($urandom_range(0, 7));
        v = 16'($urandom);
        cmd_valid   = 1'b1;
        cmd_clr     = 1'b0;
        cmd_op      = op;
        cmd_operand = v;
        repeat (3) tick();
        cmd_valid = 1'b0;
        chk("fill_blocked_level", 32'(fifo_level), 4);
        chk("fill_hold_valid", 32'(rsp_valid), 1);
        chk("fill_hold_data", 32'(rsp_data), 32'(exp_q[0]));
        get_rsp("fill_r0");
        push(1'b0, op, v);
        for (int i = 0; i < 5; i++) begin
            get_rsp("fill_drain");
        end
        chk("fill_pulses", btnd_cnt - snap_d, 6);
        chk("fill_empty", 32'(busy), 0);

        // simultaneous push and pop at level 1
        snap_d = btnd_cnt;
        push(1'b0, 3'd0, 16'h0101);
        push(1'b0, 3'd4, 16'h5a5a);
        get_rsp("pp_a");
        chk("pp_pre_level", 32'(fifo_level), 1);
        push(1'b0, 3'd1, 16'h0033);
        chk("pp_post_level", 32'(fifo_level), 1);
        chk("pp_pop_sw", 32'(calc_sw), 32'h5a5a);
        get_rsp("pp_b");
        get_rsp("pp_c");
        chk("pp_pulses", btnd_cnt - snap_d, 3);

        // reset in the middle of a strobe
        push(1'b0, 3'($urandom_range(0, 7)), 16'($urandom));
        push(1'b0, 3'($urandom_range(0, 7)), 16'($urandom));
        push(1'b0, 3'($urandom_range(0, 7)), 16'($urandom));
        k = 0;
        while (!calc_btnd && k < 20) begin
            tick();
            k++;
        end
        chk("mid_in_strobe", 32'(calc_btnd), 1);
        chk("mid_queued", 32'(fifo_level), 2);
        rst_n = 1'b0;
        #1;
        chk("mid_level", 32'(fifo_level), 0);
        chk("mid_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_btnd", 32'(calc_btnd), 0);
        chk("mid_btnu", 32'(calc_btnu), 1);
        model_acc = '0;
        exp_q.delete();
        snap_d = btnd_cnt;
        repeat (2) tick();
        rst_n = 1'b1;
        chk("mid_init_btnu", 32'(calc_btnu), 1);
        chk("mid_init_ready", 32'(cmd_ready), 0);
        tick();
        chk("mid_idle_btnu", 32'(calc_btnu), 0);
        chk("mid_idle_ready", 32'(cmd_ready), 1);
        repeat (15) tick();
        chk("mid_no_btnd", btnd_cnt - snap_d, 0);
        chk("mid_no_rsp", 32'(rsp_valid), 0);
        chk("mid_idle_busy", 32'(busy), 0);

        // sequencer still works from a cleared accumulator
        push(1'b0, 3'd0, 16'($urandom));
        get_rsp("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
